// File: rtl/alu_pkg.sv
// Shared types for the execute stage: ALU opcodes and execute FSM states.
// Opcodes 11-15 are deliberately left unnamed; the ALU treats them as undefined (result 0).
// The multiplier opcode is only honoured when the unit is built with MUL_EN=1.
package alu_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_MUL  = 4'd10
  } alu_op_e;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } exec_state_e;

  // True when the raw opcode field selects the iterative multiplier
  function automatic logic op_is_mul(input logic [ALU_OP_W-1:0] op);
    return op == ALU_MUL;
  endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit consumed per clock.
// Latency: operands latched on i_start, o_done asserted combinationally during the
// DATA_WIDTH-th busy cycle with o_product valid; caller must not start while busy.
module mul_iter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_product
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_WIDTH - 1);

  logic                  r_busy;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_mcand;
  logic [DATA_WIDTH-1:0] r_mplier;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0] w_acc_nxt;

  // Partial sum after consuming the current low multiplier bit; wraps modulo 2**DATA_WIDTH
  always_comb begin
    w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
  end

  // The final step's sum is handed out directly so the caller can register it on that edge
  assign o_done    = r_busy && (r_cnt == LAST_STEP);
  assign o_product = w_acc_nxt;

  // Operand latch on start, then one shift-add step per cycle until the last bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (i_start && !r_busy) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_acc    <= '0;
    end else if (r_busy) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (r_cnt == LAST_STEP) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/exec_unit.sv
// Execute stage: 2R/1W register file, operand select, combinational ALU, optional iterative MUL.
// Latency: single-cycle ops 1 cycle; MUL writes back DATA_WIDTH edges after acceptance.
// Backpressure: in_ready drops for the whole MUL; nothing is accepted while it runs.
module exec_unit
  import alu_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int MUL_EN        = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ALU_OP_W-1:0]      alu_op,
  input  logic                     alu_src,
  input  logic                     reg_write,
  input  logic [DATA_WIDTH-1:0]    imm_op,
  input  logic [ADDRESS_WIDTH-1:0] rs1,
  input  logic [ADDRESS_WIDTH-1:0] rs2,
  input  logic [ADDRESS_WIDTH-1:0] rd,
  output logic                     out_valid,
  output logic [DATA_WIDTH-1:0]    alu_out,
  output logic                     eq,
  output logic [DATA_WIDTH-1:0]    a0
);

  localparam int NREG  = 2 ** ADDRESS_WIDTH;
  localparam int SHW   = $clog2(DATA_WIDTH);
  localparam int A0_IX = 10;

  // Architectural state
  logic [DATA_WIDTH-1:0]    r_rf [NREG];
  exec_state_e              r_state;
  logic                     r_out_valid;
  logic [DATA_WIDTH-1:0]    r_alu_out;
  logic                     r_eq;

  // MUL context captured at acceptance, consumed at completion
  logic [ADDRESS_WIDTH-1:0] r_mul_rd;
  logic                     r_mul_we;
  logic                     r_mul_eq;

  // Combinational datapath
  logic [DATA_WIDTH-1:0]    w_op1;
  logic [DATA_WIDTH-1:0]    w_rs2_val;
  logic [DATA_WIDTH-1:0]    w_op2;
  logic [SHW-1:0]           w_shamt;
  logic [DATA_WIDTH-1:0]    w_alu_res;
  logic                     w_op_eq;
  logic                     w_is_mul;

  // FSM / handshake
  exec_state_e              w_state_nxt;
  logic                     w_accept;
  logic                     w_mul_start;
  logic                     w_single_fin;
  logic                     w_mul_fin;

  // Multiplier interface
  logic                     w_mul_done;
  logic [DATA_WIDTH-1:0]    w_mul_product;

  // Writeback port
  logic                     w_wr_en;
  logic [ADDRESS_WIDTH-1:0] w_wr_addr;
  logic [DATA_WIDTH-1:0]    w_wr_data;

  // Register file reads and operand select; x0 is forced to zero on read
  always_comb begin
    w_op1     = (rs1 == '0) ? '0 : r_rf[rs1];
    w_rs2_val = (rs2 == '0) ? '0 : r_rf[rs2];
    w_op2     = alu_src ? imm_op : w_rs2_val;
    w_op_eq   = (w_op1 == w_op2);
    w_is_mul  = (MUL_EN != 0) && op_is_mul(alu_op);
  end

  // Single-cycle ALU; MUL and unassigned codes yield 0 here (MUL result comes from mul_iter)
  always_comb begin
    w_shamt   = w_op2[SHW-1:0];
    w_alu_res = '0;
    case (alu_op)
      ALU_ADD:  w_alu_res = w_op1 + w_op2;
      ALU_SUB:  w_alu_res = w_op1 - w_op2;
      ALU_AND:  w_alu_res = w_op1 & w_op2;
      ALU_OR:   w_alu_res = w_op1 | w_op2;
      ALU_XOR:  w_alu_res = w_op1 ^ w_op2;
      ALU_SLL:  w_alu_res = w_op1 << w_shamt;
      ALU_SRL:  w_alu_res = w_op1 >> w_shamt;
      ALU_SRA:  w_alu_res = DATA_WIDTH'($signed(w_op1) >>> w_shamt);
      ALU_SLT:  w_alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(w_op1) < $signed(w_op2))};
      ALU_SLTU: w_alu_res = {{(DATA_WIDTH-1){1'b0}}, (w_op1 < w_op2)};
      default:  w_alu_res = '0;
    endcase
  end

  // Optional multiplier; without it MUL decodes as an undefined single-cycle op
  generate
    if (MUL_EN != 0) begin : g_mul
      mul_iter #(
        .DATA_WIDTH (DATA_WIDTH)
      ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_mul_start),
        .i_a       (w_op1),
        .i_b       (w_op2),
        .o_done    (w_mul_done),
        .o_product (w_mul_product)
      );
    end else begin : g_no_mul
      assign w_mul_done    = 1'b0;
      assign w_mul_product = '0;
    end
  endgenerate

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: MUL parks the unit until the multiplier reports its final step
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (w_accept && w_is_mul) w_state_nxt = MUL_BUSY;
      MUL_BUSY: if (w_mul_done)           w_state_nxt = IDLE;
      default:                            w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs: handshake and the two completion sources
  always_comb begin
    in_ready     = (r_state == IDLE);
    w_accept     = in_valid && in_ready;
    w_mul_start  = w_accept && w_is_mul;
    w_single_fin = w_accept && !w_is_mul;
    w_mul_fin    = (r_state == MUL_BUSY) && w_mul_done;
  end

  // Writeback select; the two sources are mutually exclusive by FSM state
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = '0;
    w_wr_data = '0;
    if (w_single_fin) begin
      w_wr_en   = reg_write;
      w_wr_addr = rd;
      w_wr_data = w_alu_res;
    end else if (w_mul_fin) begin
      w_wr_en   = r_mul_we;
      w_wr_addr = r_mul_rd;
      w_wr_data = w_mul_product;
    end
  end

  // Register file write; x0 writes are dropped so it stays zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_rf[i] <= '0;
      end
    end else if (w_wr_en && (w_wr_addr != '0)) begin
      r_rf[w_wr_addr] <= w_wr_data;
    end
  end

  // Capture MUL destination and EQ at acceptance, since decode inputs move on
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mul_rd <= '0;
      r_mul_we <= 1'b0;
      r_mul_eq <= 1'b0;
    end else if (w_mul_start) begin
      r_mul_rd <= rd;
      r_mul_we <= reg_write;
      r_mul_eq <= w_op_eq;
    end
  end

  // Result registers: one-cycle valid pulse, data held until the next completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_alu_out   <= '0;
      r_eq        <= 1'b0;
    end else begin
      r_out_valid <= w_single_fin || w_mul_fin;
      if (w_single_fin) begin
        r_alu_out <= w_alu_res;
        r_eq      <= w_op_eq;
      end else if (w_mul_fin) begin
        r_alu_out <= w_mul_product;
        r_eq      <= r_mul_eq;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign alu_out   = r_alu_out;
  assign eq        = r_eq;
  assign a0        = r_rf[A0_IX];

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: a MUL_EN=1 instance for the main flow and a MUL_EN=0
// instance for the no-multiplier build. Inputs change on the falling edge, outputs are
// sampled on the falling edge, so each sample sits half a cycle after the rising edge.
module tb_exec_unit;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        nm_valid;
  logic [3:0]  alu_op;
  logic        alu_src;
  logic        reg_write;
  logic [31:0] imm_op;
  logic [4:0]  rs1, rs2, rd;

  logic        in_ready, out_valid, eq;
  logic [31:0] alu_out, a0;
  logic        nm_in_ready, nm_out_valid, nm_eq;
  logic [31:0] nm_alu_out, nm_a0;

  int n_checks = 0;
  int n_errors = 0;

  exec_unit #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .MUL_EN(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .alu_src(alu_src), .reg_write(reg_write), .imm_op(imm_op),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .out_valid(out_valid), .alu_out(alu_out), .eq(eq), .a0(a0)
  );

  exec_unit #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .MUL_EN(0)) u_dut_nm (
    .clk(clk), .rst_n(rst_n), .in_valid(nm_valid), .in_ready(nm_in_ready),
    .alu_op(alu_op), .alu_src(alu_src), .reg_write(reg_write), .imm_op(imm_op),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .out_valid(nm_out_valid), .alu_out(nm_alu_out), .eq(nm_eq), .a0(nm_a0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present an op at a falling edge and return at the next falling edge (cycle after accept).
  // in_valid is left asserted so a following call issues back-to-back.
  task automatic issue(input logic sel_nm, input logic [3:0] op, input logic src,
                       input logic we, input logic [31:0] imm,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d);
    alu_op    = op;
    alu_src   = src;
    reg_write = we;
    imm_op    = imm;
    rs1       = s1;
    rs2       = s2;
    rd        = d;
    in_valid  = !sel_nm;
    nm_valid  = sel_nm;
    @(negedge clk);
  endtask

  task automatic drop();
    in_valid = 1'b0;
    nm_valid = 1'b0;
  endtask

  // Read a register by issuing OR rs,x0 without writeback
  task automatic rd_reg(input logic sel_nm, input logic [4:0] idx, output logic [31:0] v);
    issue(sel_nm, ALU_OR, 1'b0, 1'b0, 32'h0, idx, 5'd0, 5'd0);
    v = sel_nm ? nm_alu_out : alu_out;
    drop();
  endtask

  // Wait (bounded) for out_valid of the main instance; n counts cycles after the accept edge
  task automatic wait_ov(input int budget, output int n);
    n = 1;
    while (!out_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  logic [31:0] v;
  int          n;
  int          first_ov;
  int          busy_cnt;
  int          ov_cnt;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; nm_valid = 1'b0;
    alu_op = 4'd0; alu_src = 1'b0; reg_write = 1'b0; imm_op = 32'h0;
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_alu_out", alu_out, 0);
    chk("rst_eq", eq, 0);
    chk("rst_a0", a0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1. ADDI x5 = x0 + 0x123
    issue(0, ALU_ADD, 1, 1, 32'h0000_0123, 5'd0, 5'd0, 5'd5);
    chk("t1_out_valid", out_valid, 1);
    chk("t1_alu_out", alu_out, 32'h123);
    chk("t1_eq", eq, 0);
    // 2. Back-to-back dependent ops
    issue(0, ALU_ADD, 0, 1, 32'h0, 5'd5, 5'd5, 5'd6);
    chk("t2_add_out", alu_out, 32'h246);
    chk("t2_add_valid", out_valid, 1);
    chk("t2_add_eq", eq, 1);
    chk("t2_ready1", in_ready, 1);
    issue(0, ALU_SUB, 1, 1, 32'h1, 5'd6, 5'd0, 5'd10);
    chk("t2_sub_out", alu_out, 32'h245);
    chk("t2_a0", a0, 32'h245);
    chk("t2_ready2", in_ready, 1);
    drop();
    @(negedge clk);
    chk("t2_valid_pulse_end", out_valid, 0);
    rd_reg(0, 5'd5, v);
    chk("t1_x5", v, 32'h123);

    // 3. x0 write dropped, SRA/SRL/SLTU/SLT/SLL/AND, undefined op
    issue(0, ALU_ADD, 1, 1, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
    chk("t3_x0_wr_result", alu_out, 32'hFFFF_FFFF);
    drop();
    rd_reg(0, 5'd0, v);
    chk("t3_x0_reads_0", v, 32'h0);
    issue(0, ALU_ADD, 1, 1, 32'h8000_0000, 5'd0, 5'd0, 5'd1);
    issue(0, ALU_ADD, 1, 1, 32'h0000_0001, 5'd0, 5'd0, 5'd2);
    issue(0, ALU_ADD, 1, 1, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd3);
    issue(0, ALU_SRA, 1, 0, 32'h4, 5'd1, 5'd0, 5'd0);
    chk("t3_sra", alu_out, 32'hF800_0000);
    issue(0, ALU_SRL, 1, 0, 32'h4, 5'd1, 5'd0, 5'd0);
    chk("t3_srl", alu_out, 32'h0800_0000);
    issue(0, ALU_SLTU, 0, 0, 32'h0, 5'd2, 5'd3, 5'd0);
    chk("t3_sltu", alu_out, 32'h1);
    issue(0, ALU_SLT, 0, 0, 32'h0, 5'd2, 5'd3, 5'd0);
    chk("t3_slt_pos_lt_neg", alu_out, 32'h0);
    issue(0, ALU_SLT, 0, 0, 32'h0, 5'd3, 5'd2, 5'd0);
    chk("t3_slt_neg_lt_pos", alu_out, 32'h1);
    issue(0, ALU_SLL, 1, 0, 32'd36, 5'd2, 5'd0, 5'd0);
    chk("t3_sll_shamt_mask", alu_out, 32'h10);
    issue(0, ALU_AND, 0, 0, 32'h0, 5'd1, 5'd3, 5'd0);
    chk("t3_and", alu_out, 32'h8000_0000);
    issue(0, ALU_XOR, 0, 0, 32'h0, 5'd1, 5'd3, 5'd0);
    chk("t3_xor", alu_out, 32'h7FFF_FFFF);
    issue(0, ALU_ADD, 1, 1, 32'h5, 5'd0, 5'd0, 5'd4);
    issue(0, 4'd12, 1, 1, 32'h9, 5'd4, 5'd0, 5'd4);
    chk("t3_undef_result", alu_out, 32'h0);
    chk("t3_undef_valid", out_valid, 1);
    drop();
    rd_reg(0, 5'd4, v);
    chk("t3_undef_wb", v, 32'h0);

    // 4. MUL 7*6 into x7 with an ignored op pulsed while busy
    issue(0, ALU_ADD, 1, 1, 32'd7, 5'd0, 5'd0, 5'd8);
    issue(0, ALU_ADD, 1, 1, 32'd6, 5'd0, 5'd0, 5'd9);
    drop();
    @(negedge clk);
    issue(0, ALU_MUL, 0, 1, 32'h0, 5'd8, 5'd9, 5'd7);
    drop();
    first_ov = 0;
    busy_cnt = 0;
    n = 1;
    while (n <= 40) begin
      if (out_valid && first_ov == 0) first_ov = n;
      if (!in_ready) busy_cnt++;
      if (n == 5) begin
        alu_op = ALU_ADD; alu_src = 1'b1; reg_write = 1'b1;
        imm_op = 32'h55; rs1 = 5'd0; rd = 5'd11; in_valid = 1'b1;
      end
      if (n == 6) in_valid = 1'b0;
      if (first_ov != 0) break;
      @(negedge clk);
      n++;
    end
    chk("t4_ov_cycle", first_ov, 33);
    chk("t4_busy_cycles", busy_cnt, 32);
    chk("t4_product", alu_out, 32'd42);
    chk("t4_eq", eq, 0);
    @(negedge clk);
    chk("t4_ov_single", out_valid, 0);
    chk("t4_ready_back", in_ready, 1);
    rd_reg(0, 5'd7, v);
    chk("t4_x7", v, 32'd42);
    rd_reg(0, 5'd11, v);
    chk("t4_busy_op_ignored", v, 32'h0);

    // 5. MUL wrap, MUL with equal operands, then MUL aborted by reset
    issue(0, ALU_ADD, 1, 1, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd12);
    issue(0, ALU_ADD, 1, 1, 32'h2, 5'd0, 5'd0, 5'd13);
    issue(0, ALU_MUL, 0, 1, 32'h0, 5'd12, 5'd13, 5'd14);
    drop();
    wait_ov(40, n);
    chk("t5_wrap_cycle", n, 33);
    chk("t5_wrap", alu_out, 32'hFFFF_FFFE);
    @(negedge clk);
    issue(0, ALU_MUL, 0, 1, 32'h0, 5'd13, 5'd13, 5'd15);
    drop();
    wait_ov(40, n);
    chk("t5_sq", alu_out, 32'h4);
    chk("t5_sq_eq", eq, 1);
    @(negedge clk);
    issue(0, ALU_MUL, 0, 1, 32'h0, 5'd8, 5'd9, 5'd16);
    drop();
    repeat (9) @(negedge clk);
    chk("t5_busy_before_abort", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("t5_abort_ready", in_ready, 1);
    chk("t5_abort_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ov_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) ov_cnt++;
      @(negedge clk);
    end
    chk("t5_abort_no_ov", ov_cnt, 0);
    rd_reg(0, 5'd16, v);
    chk("t5_abort_no_wb", v, 32'h0);

    // 6. MUL_EN=0 build: MUL and op 15 are single-cycle, result 0
    issue(1, ALU_ADD, 1, 1, 32'h5, 5'd0, 5'd0, 5'd1);
    chk("t6_setup", nm_alu_out, 32'h5);
    issue(1, ALU_MUL, 1, 1, 32'h5, 5'd1, 5'd0, 5'd2);
    chk("t6_mul_valid", nm_out_valid, 1);
    chk("t6_mul_result", nm_alu_out, 32'h0);
    chk("t6_mul_eq", nm_eq, 1);
    chk("t6_mul_ready", nm_in_ready, 1);
    issue(1, 4'd15, 0, 0, 32'h0, 5'd1, 5'd0, 5'd0);
    chk("t6_op15_result", nm_alu_out, 32'h0);
    chk("t6_op15_eq", nm_eq, 0);
    drop();
    rd_reg(1, 5'd2, v);
    chk("t6_mul_wb", v, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
